// File: rtl/result_writer_pkg.sv
// ----------------------------------------------------------------------------
// result_writer_pkg
// Shared constants and types for the result writer:
//   WORD_W / REC_W        emitted word width and record width
//   COUNT_W               width of the record counters
//   DEFAULT_RECORD_LIMIT  default number of records before the block stops
//   state_t               serializer FSM state encoding
//   high_word / low_word  record halves in emission order
// ----------------------------------------------------------------------------
package result_writer_pkg;

    localparam int WORD_W               = 32;
    localparam int REC_W                = 64;
    localparam int COUNT_W              = 17;
    localparam int DEFAULT_RECORD_LIMIT = 51;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A record is {high word, low word}; the high word goes out first.
    function automatic logic [WORD_W-1:0] high_word(input logic [REC_W-1:0] rec);
        return rec[REC_W-1:WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] low_word(input logic [REC_W-1:0] rec);
        return rec[WORD_W-1:0];
    endfunction

endpackage : result_writer_pkg

// File: rtl/result_writer_if.sv
// ----------------------------------------------------------------------------
// result_writer_if
// Record-in / word-out handshake bundle of the result writer.
//   rec_valid  / rec_ready  / rec_data[63:0]   record channel (into the writer)
//   word_valid / word_ready / word_data[31:0]  word channel (out of the writer)
//   word_last                                  final word of the final record
// Modports:
//   slave  - the result writer itself
//   master - the environment: record producer and word sink
// ----------------------------------------------------------------------------
interface result_writer_if;
    import result_writer_pkg::*;

    logic              rec_valid;
    logic              rec_ready;
    logic [REC_W-1:0]  rec_data;

    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              word_last;

    modport slave (
        input  rec_valid, rec_data, word_ready,
        output rec_ready, word_valid, word_data, word_last
    );

    modport master (
        output rec_valid, rec_data, word_ready,
        input  rec_ready, word_valid, word_data, word_last
    );

endinterface : result_writer_if

// File: rtl/result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo
// Synchronous first-word-fall-through FIFO buffering records for the writer.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset, empties the FIFO
//   push       write push_data (ignored when full)
//   push_data  entry to write
//   pop        discard the head entry (ignored when empty)
//   pop_data   head entry, valid whenever !empty
//   full       no room for another entry
//   empty      no entry stored
// ----------------------------------------------------------------------------
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_fifo: DEPTH must be a power of two and at least 2");
    end

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    // One extra pointer bit tells a full FIFO from an empty one when the
    // address bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are meaningful, and a reset on the array would keep it
    // from mapping onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule : result_fifo

// File: rtl/result_writer.sv
// ----------------------------------------------------------------------------
// result_writer
// Buffers 64-bit records in a FIFO and emits each as two 32-bit words, high
// word first, until RECORD_LIMIT records have been emitted; then it parks in
// DONE until reset.
// Parameters:
//   RECORD_LIMIT  records emitted before stopping (1 .. 2^17-1)
//   FIFO_DEPTH    record buffer depth (power of two, >= 2)
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   bus        result_writer_if.slave: record in, word out handshakes
//   rec_count  records fully emitted
//   done       limit reached
//   checksum   (only with RESULT_WRITER_CHECKSUM_EN) sum mod 2^32 of every
//              word transferred
// Optional feature macro: RESULT_WRITER_CHECKSUM_EN
// ----------------------------------------------------------------------------
module result_writer
    import result_writer_pkg::*;
#(
    parameter int RECORD_LIMIT = DEFAULT_RECORD_LIMIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset,
    result_writer_if.slave     bus,
    output logic [COUNT_W-1:0] rec_count,
    output logic               done
`ifdef RESULT_WRITER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]  checksum
`endif
);

    if (RECORD_LIMIT < 1 || RECORD_LIMIT > (1 << COUNT_W) - 1) begin : g_bad_limit
        $error("result_writer: RECORD_LIMIT must be in 1 .. 2^17-1");
    end

    localparam logic [COUNT_W-1:0] LIMIT     = COUNT_W'(RECORD_LIMIT);
    localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(RECORD_LIMIT - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t             state;
    logic [REC_W-1:0]   hold;
    logic [COUNT_W-1:0] acc_count;

    logic               word_valid_q;
    logic [WORD_W-1:0]  word_data_q;
    logic               word_last_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REC_W-1:0]   fifo_head;

    // The record in hold is the last one allowed through.
    logic               last_rec;

    assign last_rec = (rec_count == LAST_IDX);

    // ------------------------------------------------------------------
    // Record intake
    // ------------------------------------------------------------------
    // Acceptance stops once RECORD_LIMIT records have been taken, even if
    // they are still queued, so nothing beyond the limit is ever buffered.
    assign bus.rec_ready = !fifo_full && (acc_count < LIMIT);
    assign fifo_push     = bus.rec_valid && bus.rec_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_count <= '0;
        end else if (fifo_push && acc_count != LIMIT) begin
            acc_count <= acc_count + COUNT_ONE;
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.rec_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Pop decision
    // ------------------------------------------------------------------
    // Popping straight from LOW into HIGH keeps the word stream gap-free.
    // NOTE: the default assignment ahead of the case guarantees fifo_pop is
    // driven on every path, so no latch is inferred.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            LOW:     fifo_pop = bus.word_ready && !last_rec && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer FSM with registered outputs
    // ------------------------------------------------------------------
    // word_data / word_last only change on a transition that needs
    // word_ready, so they hold steady while the sink stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= '0;
            rec_count    <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_last_q  <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold         <= fifo_head;
                        state        <= HIGH;
                        word_valid_q <= 1'b1;
                        word_data_q  <= high_word(fifo_head);
                        word_last_q  <= 1'b0;
                    end
                end

                HIGH: begin
                    if (bus.word_ready) begin
                        state       <= LOW;
                        word_data_q <= low_word(hold);
                        word_last_q <= last_rec;
                    end
                end

                LOW: begin
                    if (bus.word_ready) begin
                        // LOW is only reachable below the limit, so the
                        // increment saturates at RECORD_LIMIT by construction.
                        rec_count <= rec_count + COUNT_ONE;
                        if (last_rec) begin
                            state        <= DONE;
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                            done         <= 1'b1;
                        end else if (!fifo_empty) begin
                            hold         <= fifo_head;
                            state        <= HIGH;
                            word_data_q  <= high_word(fifo_head);
                            word_last_q  <= 1'b0;
                        end else begin
                            state        <= IDLE;
                            word_valid_q <= 1'b0;
                            word_last_q  <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    word_valid_q <= 1'b0;
                    word_last_q  <= 1'b0;
                    done         <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.word_valid = word_valid_q;
    assign bus.word_data  = word_data_q;
    assign bus.word_last  = word_last_q;

    // ------------------------------------------------------------------
    // Optional running checksum of transferred words
    // ------------------------------------------------------------------
`ifdef RESULT_WRITER_CHECKSUM_EN
    logic word_fire;

    assign word_fire = word_valid_q && bus.word_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= '0;
        end else if (word_fire) begin
            checksum <= checksum + word_data_q;
        end
    end
`endif

endmodule : result_writer

// File: tb/tb_result_writer.sv
// ----------------------------------------------------------------------------
// tb_result_writer
// Two writers share clock and reset: dut_a uses the default limit (51),
// dut_b a limit of 3. A reference model in the monitor turns every accepted
// record into its two expected words and compares whatever each writer offers.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_writer;
    import result_writer_pkg::*;

    localparam int NDUT  = 2;
    localparam int LIM_A = DEFAULT_RECORD_LIMIT;
    localparam int LIM_B = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    result_writer_if bus_a();
    result_writer_if bus_b();

    // Stimulus, per writer
    logic        rv   [NDUT];
    logic [63:0] rdat [NDUT];
    logic        wrdy [NDUT];

    // Observed outputs, per writer
    logic        rrdy [NDUT];
    logic        wv   [NDUT];
    logic [31:0] wd   [NDUT];
    logic        wl   [NDUT];
    logic [16:0] cnt  [NDUT];
    logic        dn   [NDUT];
`ifdef RESULT_WRITER_CHECKSUM_EN
    logic [31:0] csum [NDUT];
`endif

    assign bus_a.rec_valid  = rv[0];
    assign bus_a.rec_data   = rdat[0];
    assign bus_a.word_ready = wrdy[0];
    assign bus_b.rec_valid  = rv[1];
    assign bus_b.rec_data   = rdat[1];
    assign bus_b.word_ready = wrdy[1];

    assign rrdy[0] = bus_a.rec_ready;
    assign wv[0]   = bus_a.word_valid;
    assign wd[0]   = bus_a.word_data;
    assign wl[0]   = bus_a.word_last;
    assign rrdy[1] = bus_b.rec_ready;
    assign wv[1]   = bus_b.word_valid;
    assign wd[1]   = bus_b.word_data;
    assign wl[1]   = bus_b.word_last;

    result_writer #(.RECORD_LIMIT(LIM_A), .FIFO_DEPTH(4)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_a),
        .rec_count (cnt[0]),
        .done      (dn[0])
`ifdef RESULT_WRITER_CHECKSUM_EN
        ,
        .checksum  (csum[0])
`endif
    );

    result_writer #(.RECORD_LIMIT(LIM_B), .FIFO_DEPTH(4)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_b),
        .rec_count (cnt[1]),
        .done      (dn[1])
`ifdef RESULT_WRITER_CHECKSUM_EN
        ,
        .checksum  (csum[1])
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + monitor
    // Each accepted record yields two queue entries {is_low, last, word}.
    // ------------------------------------------------------------------
    int          lim      [NDUT] = '{LIM_A, LIM_B};
    logic [33:0] exp_q    [NDUT][$];
    int          m_acc    [NDUT];
    int          m_done   [NDUT];
    logic [31:0] m_sum    [NDUT];
    bit          stall_p  [NDUT];
    logic [32:0] stall_w  [NDUT];

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            m_acc[d] = 0; m_done[d] = 0; m_sum[d] = '0; stall_p[d] = 1'b0; stall_w[d] = '0;
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < NDUT; d++) begin
            if (reset) begin
                exp_q[d].delete();
                m_acc[d]   = 0;
                m_done[d]  = 0;
                m_sum[d]   = '0;
                stall_p[d] = 1'b0;
            end else begin
                logic [33:0] head;
                check($sformatf("rec_count[%0d]", d), cnt[d], m_done[d]);
                check($sformatf("done[%0d]", d), dn[d], m_done[d] == lim[d]);
`ifdef RESULT_WRITER_CHECKSUM_EN
                check($sformatf("checksum[%0d]", d), csum[d], m_sum[d]);
`endif
                if (m_acc[d] >= lim[d])
                    check($sformatf("rec_ready closed at limit[%0d]", d), rrdy[d], 1'b0);
                if (stall_p[d])
                    check($sformatf("word stable while stalled[%0d]", d),
                          {wv[d], wl[d], wd[d]}, {1'b1, stall_w[d]});
                if (exp_q[d].size() == 0) begin
                    check($sformatf("word_valid with nothing pending[%0d]", d), wv[d], 1'b0);
                end else if (wv[d]) begin
                    head = exp_q[d][0];
                    check($sformatf("word {last,data}[%0d]", d), {wl[d], wd[d]}, head[32:0]);
                    if (wrdy[d]) begin
                        void'(exp_q[d].pop_front());
                        m_sum[d] = m_sum[d] + head[31:0];
                        if (head[33]) m_done[d]++;
                    end
                end
                stall_p[d] = wv[d] && !wrdy[d];
                stall_w[d] = {wl[d], wd[d]};
                if (rv[d] && rrdy[d] && m_acc[d] < lim[d]) begin
                    exp_q[d].push_back({1'b0, 1'b0, rdat[d][63:32]});
                    exp_q[d].push_back({1'b1, (m_acc[d] == lim[d] - 1), rdat[d][31:0]});
                    m_acc[d]++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic send(input int d, input logic [63:0] data, output bit ok);
        ok      = 1'b0;
        rv[d]   = 1'b1;
        rdat[d] = data;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clock);
            if (rrdy[d]) ok = 1'b1;
            tick();
        end
        rv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        bit fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            wrdy[d] = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (exp_q[d].size() == 0 && !wv[d]) fin = 1'b1;
            tick();
        end
        check($sformatf("drain completes[%0d]", d), fin, 1'b1);
        wrdy[d] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed and random scenarios
    // ------------------------------------------------------------------
    initial begin
        bit ok;
        bit found;
        bit feed_done;
        int run;
        int acc;
        int words;
        int last_at;

        for (int d = 0; d < NDUT; d++) begin
            rv[d] = 1'b0; rdat[d] = '0; wrdy[d] = 1'b0;
        end
        tick();
        do_reset(3);

        // Reset values, one cycle after reset
        @(negedge clock);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset rec_ready[%0d]", d), rrdy[d], 1'b1);
            check($sformatf("reset word_valid[%0d]", d), wv[d], 1'b0);
            check($sformatf("reset word_last[%0d]", d), wl[d], 1'b0);
            check($sformatf("reset done[%0d]", d), dn[d], 1'b0);
            check($sformatf("reset rec_count[%0d]", d), cnt[d], 17'd0);
        end
        tick();

        // Single record latency: accept at E, high word at E+2, low at E+3
        wrdy[0] = 1'b1;
        rv[0]   = 1'b1;
        rdat[0] = 64'h00000001_00000002;
        @(negedge clock);
        check("latency rec_ready", rrdy[0], 1'b1);
        tick();
        rv[0] = 1'b0;
        @(negedge clock);
        check("latency no word after E", wv[0], 1'b0);
        @(negedge clock);
        check("latency high word before E+2", {wv[0], wd[0]}, {1'b1, 32'h1});
        @(negedge clock);
        check("latency low word before E+3", {wv[0], wl[0], wd[0]}, {1'b1, 1'b0, 32'h2});
        @(negedge clock);
        check("latency idle after", wv[0], 1'b0);
        check("latency rec_count", cnt[0], 17'd1);
        tick();

        // Stalled sink: high word holds, FIFO fills, intake closes
        wrdy[0] = 1'b0;
        send(0, 64'hAAAA5555_12345678, ok);
        check("stall first accepted", ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(0, {$urandom, $urandom}, ok);
            check($sformatf("stall fill %0d accepted", i), ok, 1'b1);
        end
        rv[0]   = 1'b1;
        rdat[0] = {$urandom, $urandom};
        repeat (5) begin
            @(negedge clock);
            check("stall rec_ready low", rrdy[0], 1'b0);
            check("stall high word held", {wv[0], wd[0]}, {1'b1, 32'hAAAA5555});
            tick();
        end
        rv[0] = 1'b0;
        drain(0);

        // Random traffic with random sink back-pressure
        feed_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(0, {$urandom, $urandom}, ok);
                    check("random record accepted", ok, 1'b1);
                end
                feed_done = 1'b1;
            end
            begin
                while (!feed_done) begin
                    wrdy[0] = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain(0);

        // Reset right after the high-word handshake discards the rest
        wrdy[0] = 1'b1;
        found   = 1'b0;
        fork
            begin
                send(0, 64'hCAFE0001_0000BEEF, ok);
                send(0, {$urandom, $urandom}, ok);
                send(0, {$urandom, $urandom}, ok);
            end
            begin
                for (int i = 0; i < 30 && !found; i++) begin
                    @(negedge clock);
                    if (wv[0] && wrdy[0] && wd[0] == 32'hCAFE0001) found = 1'b1;
                end
                @(posedge clock);
                #1;
                reset = 1'b1;
            end
        join
        check("mid-record high word seen", found, 1'b1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post-reset word_valid", wv[0], 1'b0);
        check("post-reset word_last", wl[0], 1'b0);
        check("post-reset done", dn[0], 1'b0);
        check("post-reset rec_count", cnt[0], 17'd0);
        check("post-reset rec_ready", rrdy[0], 1'b1);
        tick();
        repeat (10) begin
            @(negedge clock);
            check("no word after mid-record reset", wv[0], 1'b0);
            tick();
        end

        // Default limit: 51 back-to-back records -> 102 consecutive words
        wrdy[0] = 1'b1;
        run     = 0;
        fork
            begin
                for (int i = 0; i < LIM_A; i++) begin
                    send(0, {$urandom, $urandom}, ok);
                    check("limit feed accepted", ok, 1'b1);
                end
            end
            begin
                found = 1'b0;
                for (int i = 0; i < 40 && !found; i++) begin
                    @(negedge clock);
                    if (wv[0]) found = 1'b1;
                end
                check("limit first word appears", found, 1'b1);
                for (int k = 0; k < 2 * LIM_A; k++) begin
                    if (wv[0] && wrdy[0]) run++;
                    if (k < 2 * LIM_A - 1) @(negedge clock);
                end
                check("limit consecutive words", run, 2 * LIM_A);
                @(negedge clock);
                check("limit done", dn[0], 1'b1);
                check("limit rec_count", cnt[0], 17'(LIM_A));
                check("limit word_valid low", wv[0], 1'b0);
                check("limit rec_ready low", rrdy[0], 1'b0);
            end
        join
        tick();
        rv[0]   = 1'b1;
        rdat[0] = {$urandom, $urandom};
        repeat (5) begin
            @(negedge clock);
            check("done ignores rec_valid", {rrdy[0], wv[0], dn[0]}, {1'b0, 1'b0, 1'b1});
            tick();
        end
        rv[0] = 1'b0;

        // Limit of 3: offer 5 records, only 3 go through
        wrdy[1] = 1'b1;
        acc     = 0;
        words   = 0;
        last_at = -1;
        rv[1]   = 1'b1;
        rdat[1] = {$urandom, $urandom};
        repeat (30) begin
            @(negedge clock);
            if (wv[1] && wrdy[1]) begin
                words++;
                if (wl[1]) last_at = words;
            end
            ok = rrdy[1];
            if (ok) acc++;
            tick();
            if (ok) rdat[1] = {$urandom, $urandom};
            if (acc >= 5) rv[1] = 1'b0;
        end
        rv[1] = 1'b0;
        @(negedge clock);
        check("limit3 accepted", acc, 3);
        check("limit3 words", words, 6);
        check("limit3 word_last position", last_at, 6);
        check("limit3 done", dn[1], 1'b1);
        check("limit3 rec_count", cnt[1], 17'd3);
        tick();

`ifdef RESULT_WRITER_CHECKSUM_EN
        // Checksum of {1,2} and {3,4}
        do_reset(2);
        wrdy[0] = 1'b1;
        send(0, 64'h00000001_00000002, ok);
        send(0, 64'h00000003_00000004, ok);
        drain(0);
        @(negedge clock);
        check("checksum of 1+2+3+4", csum[0], 32'd10);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_result_writer
